l2_burst_miss_fsm: RTL and testbench

Parametrised miss controller between an L1 cache and the L2. It supersedes the single-beat blocking controller with three additions: multi-beat line transfers, a valid/stall request handshake held per beat, and explicit address generation. On a miss it optionally writes back the dirty victim line beat by beat, then fetches the missing line beat by beat, writes each beat into the L1 line buffer, and pulses a completion signal so the L1 can replay the access.

---
 rtl/l2_burst_miss_fsm.sv | 193 +++++++++++++++++++
 tb/tb_l2_burst_miss_fsm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_burst_miss_fsm.sv
// Burst miss controller between L1 and L2: optional beat-by-beat write-back of the
// dirty victim, beat-by-beat refill, completion pulse. Optional macro: L2_TIMEOUT_EN.
module l2_burst_miss_fsm #(
  parameter int ADDR_W  = 32,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miss,
  input  logic                  dirty,
  input  logic                  rw_prev,
  input  logic [ADDR_W-1:0]     miss_addr,
  input  logic [ADDR_W-1:0]     victim_addr,
  input  logic                  l2_stall,
  input  logic                  l2_done,
  output logic                  l2_valid,
  output logic                  l2_rw,
  output logic [ADDR_W-1:0]     l2_addr,
  output logic                  buf_rd_valid,
  output logic                  buf_we,
  output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] buf_beat,
  output logic                  busy,
  output logic                  stall_out,
  output logic                  stall_out_d,
  output logic                  fill_rw,
  output logic                  timeout_err
);

  localparam int BW  = $clog2(BEATS);
  localparam int BFW = (BW < 1) ? 1 : BW;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << BW) - ADDR_W'(1));
  localparam logic [BFW-1:0]    LAST_BEAT = BFW'(BEATS - 1);

  if (BEATS < 1 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
    $error("BEATS must be a power of two");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, FILL_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [BFW-1:0]    beat, beat_nxt;
  logic [ADDR_W-1:0] victim_line, victim_line_nxt;
  logic [ADDR_W-1:0] miss_line, miss_line_nxt;
  logic              rw_cap, rw_cap_nxt;
  logic              fill_we_nxt;
  logic              tmo_fire;

`ifdef L2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;
  logic          in_wait;

  assign in_wait  = (state == WB_WAIT) || (state == RD_WAIT);
  assign tmo_fire = in_wait && !l2_done && (tmr == TW'(TIMEOUT - 1));

  // Timer restarts on every state change, so each WAIT visit gets a full window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!in_wait || state_nxt != state) tmr <= '0;
      else                                tmr <= tmr + TW'(1);
      if (tmo_fire) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt       = state;
    beat_nxt        = beat;
    victim_line_nxt = victim_line;
    miss_line_nxt   = miss_line;
    rw_cap_nxt      = rw_cap;
    fill_we_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (miss && !l2_stall) begin
          victim_line_nxt = victim_addr & LINE_MASK;
          miss_line_nxt   = miss_addr & LINE_MASK;
          rw_cap_nxt      = rw_prev;
          beat_nxt        = '0;
          state_nxt       = dirty ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        if (!l2_stall) state_nxt = WB_WAIT;
      end
      WB_WAIT: begin
        if (l2_done) begin
          if (beat == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = RD_REQ;
          end else begin
            beat_nxt  = beat + BFW'(1);
            state_nxt = WB_REQ;
          end
        end else if (tmo_fire) begin
          state_nxt = WB_REQ;
        end
      end
      RD_REQ: begin
        if (!l2_stall) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (l2_done) begin
          fill_we_nxt = 1'b1;
          if (beat == LAST_BEAT) begin
            state_nxt = FILL_DONE;
          end else begin
            beat_nxt  = beat + BFW'(1);
            state_nxt = RD_REQ;
          end
        end else if (tmo_fire) begin
          state_nxt = RD_REQ;
        end
      end
      FILL_DONE: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      beat        <= '0;
      victim_line <= '0;
      miss_line   <= '0;
      rw_cap      <= 1'b0;
    end else begin
      state       <= state_nxt;
      beat        <= beat_nxt;
      victim_line <= victim_line_nxt;
      miss_line   <= miss_line_nxt;
      rw_cap      <= rw_cap_nxt;
    end
  end

  // Outputs are decoded from the next state so they line up with state entry.
  // The completion pulse trails the last buffer write by one cycle so the
  // replayed access sees the complete line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      l2_valid     <= 1'b0;
      l2_rw        <= 1'b0;
      l2_addr      <= '0;
      buf_rd_valid <= 1'b0;
      buf_we       <= 1'b0;
      buf_beat     <= '0;
      busy         <= 1'b0;
      stall_out    <= 1'b0;
      stall_out_d  <= 1'b0;
      fill_rw      <= 1'b0;
    end else begin
      l2_valid     <= (state_nxt == WB_REQ) || (state_nxt == RD_REQ);
      l2_rw        <= (state_nxt == WB_REQ);
      buf_rd_valid <= (state_nxt == WB_REQ);
      buf_we       <= fill_we_nxt;
      busy         <= (state_nxt != IDLE);
      stall_out    <= (state == FILL_DONE);
      fill_rw      <= (state == FILL_DONE) && rw_cap;
      stall_out_d  <= stall_out;

      case (state_nxt)
        WB_REQ:  l2_addr <= victim_line_nxt | ADDR_W'(beat_nxt);
        RD_REQ:  l2_addr <= miss_line_nxt | ADDR_W'(beat_nxt);
        default: l2_addr <= '0;
      endcase

      // A received beat's index takes priority over the next request's index.
      if (fill_we_nxt)
        buf_beat <= beat;
      else if (state_nxt == WB_REQ || state_nxt == RD_REQ)
        buf_beat <= beat_nxt;
      else
        buf_beat <= '0;
    end
  end

endmodule

// File: tb/tb_l2_burst_miss_fsm.sv
// Directed bench for l2_burst_miss_fsm (BEATS=4, TIMEOUT=8); covers L2_TIMEOUT_EN
// builds as well as the default build.
module tb_l2_burst_miss_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic        miss, dirty, rw_prev;
  logic [31:0] miss_addr, victim_addr;
  logic        l2_stall, l2_done;
  logic        l2_valid, l2_rw, buf_rd_valid, buf_we, busy;
  logic        stall_out, stall_out_d, fill_rw, timeout_err;
  logic [31:0] l2_addr;
  logic [1:0]  buf_beat;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int acc_cnt = 0;
  int so_cnt = 0;
  int base_we, base_acc, base_so;

  l2_burst_miss_fsm #(.ADDR_W(32), .BEATS(4), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .miss(miss), .dirty(dirty), .rw_prev(rw_prev),
    .miss_addr(miss_addr), .victim_addr(victim_addr), .l2_stall(l2_stall),
    .l2_done(l2_done), .l2_valid(l2_valid), .l2_rw(l2_rw), .l2_addr(l2_addr),
    .buf_rd_valid(buf_rd_valid), .buf_we(buf_we), .buf_beat(buf_beat), .busy(busy),
    .stall_out(stall_out), .stall_out_d(stall_out_d), .fill_rw(fill_rw),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Event counters read pre-edge values at the rising edge.
  always @(posedge clock) begin
    if (buf_we) we_cnt++;
    if (l2_valid && !l2_stall) acc_cnt++;
    if (stall_out) so_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Current cycle is a REQ state for the given beat; completes it with l2_done
  // one cycle after acceptance and checks the beat's buffer write.
  task automatic do_beat(input logic rw, input logic [31:0] addr, input logic [1:0] bt);
    check("req_valid", l2_valid, 1);
    check("req_rw", l2_rw, rw);
    check("req_buf_rd", buf_rd_valid, rw);
    check("req_addr", l2_addr, addr);
    if (rw) check("wb_beat", buf_beat, bt);
    l2_stall = 1'b0;
    step();
    check("wait_valid_busy", {l2_valid, busy}, 2'b01);
    l2_done = 1'b1;
    step();
    l2_done = 1'b0;
    check("buf_we", buf_we, !rw);
    if (!rw) check("fill_beat", buf_beat, bt);
  endtask

  // Current cycle is FILL_DONE; checks the completion pulse and its delayed copy.
  task automatic finish_fill(input logic exp_rw);
    check("filldone_busy_valid_so", {busy, l2_valid, stall_out}, 3'b100);
    step();
    check("so_pulse", {stall_out, busy}, 2'b10);
    check("fill_rw", fill_rw, exp_rw);
    step();
    check("so_d", {stall_out, stall_out_d}, 2'b01);
  endtask

  task automatic start_miss(input logic d, input logic rw, input logic [31:0] ma,
                            input logic [31:0] va);
    miss = 1'b1; dirty = d; rw_prev = rw; miss_addr = ma; victim_addr = va;
    step();
    miss = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    miss = 1'b0; dirty = 1'b0; rw_prev = 1'b0;
    miss_addr = '0; victim_addr = '0;
    l2_stall = 1'b0; l2_done = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_flags", {l2_valid, l2_rw, buf_rd_valid, buf_we, busy, stall_out,
                        stall_out_d, fill_rw, timeout_err}, 9'b0);
    check("rst_addr", l2_addr, 32'h0);
    check("rst_beat", buf_beat, 2'd0);
    reset = 1'b0;
    step();

    // Clean miss: reads 0x100..0x103, stall_out in cycle 10.
    base_we = we_cnt; base_acc = acc_cnt;
    start_miss(1'b0, 1'b1, 32'h0000_0100, 32'h0000_02A0);
    do_beat(1'b0, 32'h100, 2'd0);
    do_beat(1'b0, 32'h101, 2'd1);
    do_beat(1'b0, 32'h102, 2'd2);
    do_beat(1'b0, 32'h103, 2'd3);
    finish_fill(1'b1);
    check("clean_we_count", we_cnt - base_we, 4);
    check("clean_accepts", acc_cnt - base_acc, 4);

    // Dirty miss: write-back 0x2A0..0x2A3, then reads. Low address bits ignored.
    base_we = we_cnt; base_acc = acc_cnt;
    start_miss(1'b1, 1'b0, 32'h0000_0102, 32'h0000_02A3);
    do_beat(1'b1, 32'h2A0, 2'd0);
    do_beat(1'b1, 32'h2A1, 2'd1);
    do_beat(1'b1, 32'h2A2, 2'd2);
    do_beat(1'b1, 32'h2A3, 2'd3);
    do_beat(1'b0, 32'h100, 2'd0);
    do_beat(1'b0, 32'h101, 2'd1);
    do_beat(1'b0, 32'h102, 2'd2);
    do_beat(1'b0, 32'h103, 2'd3);
    finish_fill(1'b0);
    check("dirty_we_count", we_cnt - base_we, 4);
    check("dirty_accepts", acc_cnt - base_acc, 8);

    // Stall for 3 cycles on read beat 2: request held 4 cycles, one acceptance.
    base_acc = acc_cnt;
    start_miss(1'b0, 1'b0, 32'h0000_0100, 32'h0000_02A0);
    do_beat(1'b0, 32'h100, 2'd0);
    do_beat(1'b0, 32'h101, 2'd1);
    l2_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_hold_valid", l2_valid, 1);
      check("stall_hold_addr", l2_addr, 32'h102);
      step();
    end
    l2_stall = 1'b0;
    do_beat(1'b0, 32'h102, 2'd2);
    do_beat(1'b0, 32'h103, 2'd3);
    finish_fill(1'b0);
    check("stall_accepts", acc_cnt - base_acc, 4);

    // Spurious l2_done in IDLE and REQ, miss held while busy.
    base_we = we_cnt;
    l2_done = 1'b1;
    step();
    l2_done = 1'b0;
    check("idle_done_ignored", {busy, l2_valid, buf_we}, 3'b000);
    start_miss(1'b0, 1'b0, 32'h0000_0100, 32'h0000_02A0);
    miss = 1'b1; dirty = 1'b1; miss_addr = 32'h300; victim_addr = 32'h500;
    l2_stall = 1'b1; l2_done = 1'b1;
    step();
    l2_done = 1'b0;
    check("req_done_valid", l2_valid, 1);
    check("req_done_addr", l2_addr, 32'h100);
    check("req_done_no_we", buf_we, 0);
    do_beat(1'b0, 32'h100, 2'd0);
    do_beat(1'b0, 32'h101, 2'd1);
    do_beat(1'b0, 32'h102, 2'd2);
    miss = 1'b0;
    do_beat(1'b0, 32'h103, 2'd3);
    finish_fill(1'b0);
    check("spurious_we_count", we_cnt - base_we, 4);

    // Reset during WB_WAIT of beat 1: outputs clear at once, no completion.
    base_so = so_cnt;
    start_miss(1'b1, 1'b1, 32'h0000_0100, 32'h0000_02A0);
    do_beat(1'b1, 32'h2A0, 2'd0);
    step();
    check("wbwait1_state", {l2_valid, busy}, 2'b01);
    #2 reset = 1'b1;
    #1;
    check("async_rst_flags", {l2_valid, l2_rw, buf_rd_valid, buf_we, busy,
                              stall_out, stall_out_d, fill_rw}, 8'b0);
    check("async_rst_addr", l2_addr, 32'h0);
    @(negedge clock);
    step();
    reset = 1'b0;
    step();
    check("rst_no_so", so_cnt - base_so, 0);
    check("rst_idle", busy, 0);
    start_miss(1'b0, 1'b0, 32'h0000_0100, 32'h0000_02A0);
    do_beat(1'b0, 32'h100, 2'd0);
    do_beat(1'b0, 32'h101, 2'd1);
    do_beat(1'b0, 32'h102, 2'd2);
    do_beat(1'b0, 32'h103, 2'd3);
    finish_fill(1'b0);
    check("post_rst_one_so", so_cnt - base_so, 1);

    // l2_done withheld in RD_WAIT of beat 0.
    start_miss(1'b0, 1'b1, 32'h0000_0100, 32'h0000_02A0);
    check("tmo_req_addr", l2_addr, 32'h100);
    step();
    repeat (8) step();
`ifdef L2_TIMEOUT_EN
    check("tmo_reissue_err", timeout_err, 1);
    do_beat(1'b0, 32'h100, 2'd0);
`else
    check("no_tmo_waiting", {l2_valid, busy, timeout_err}, 3'b010);
    repeat (4) step();
    check("no_tmo_still_waiting", {l2_valid, busy, timeout_err}, 3'b010);
    l2_done = 1'b1;
    step();
    l2_done = 1'b0;
    check("late_done_we", buf_we, 1);
    check("late_done_beat", buf_beat, 2'd0);
`endif
    do_beat(1'b0, 32'h101, 2'd1);
    do_beat(1'b0, 32'h102, 2'd2);
    do_beat(1'b0, 32'h103, 2'd3);
    finish_fill(1'b1);
`ifdef L2_TIMEOUT_EN
    check("tmo_err_sticky", timeout_err, 1);
`else
    check("tmo_err_tied", timeout_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
